// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the extended synchronous FIFO
package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Thresholds must be reachable by a count in 0..DEPTH.
    function automatic bit fifo_params_legal(input int addr_width, input int af_thresh,
                                             input int ae_thresh);
        int depth;
        depth = fifo_depth(addr_width);
        return (addr_width >= 1) && (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - register array, one synchronous write port, one asynchronous read port
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ext.sv
// rtl/sync_fifo_ext.sv - single-clock FIFO with STD/FWFT read, programmable flags, flush and sticky errors
module sync_fifo_ext
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         ADDR_WIDTH = 5,
    parameter fifo_mode_t MODE       = FIFO_STD,
    parameter int         AF_THRESH  = 28,
    parameter int         AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   avail,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH    = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_V    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_V    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    if (!fifo_params_legal(ADDR_WIDTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_ext: threshold parameters out of range");
    end

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  rd_accept, wr_accept, mem_we;
    logic [DATA_WIDTH-1:0] rdata;

    // The extra pointer bit disambiguates full from empty.
    assign count        = wptr_q - rptr_q;
    assign avail        = DEPTH_V - count;
    assign full         = (count == DEPTH_V);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_V);
    assign almost_empty = (count <= AE_V);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A read on a full FIFO frees the slot the same-cycle write lands in.
    assign rd_accept = rd_en & ~empty;
    assign wr_accept = wr_en & (~full | rd_accept);
    assign mem_we    = wr_accept & ~flush;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) wptr_d = wptr_q + PTR_ONE;
            if (rd_accept) rptr_d = rptr_q + PTR_ONE;
            if (wr_en && !wr_accept) overflow_d = 1'b1;
            if (rd_en && !rd_accept) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_2p #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .we_i   (mem_we),
        .waddr_i(wptr_q[ADDR_WIDTH-1:0]),
        .wdata_i(data_in),
        .raddr_i(rptr_q[ADDR_WIDTH-1:0]),
        .rdata_o(rdata)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Memory is never cleared, so the head is masked while nothing is stored.
        assign data_out = empty ? '0 : rdata;
        assign rd_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  valid_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else if (flush) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_accept;
                if (rd_accept) dout_q <= rdata;
            end
        end

        assign data_out = dout_q;
        assign rd_valid = valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb/tb_sync_fifo_ext.sv - self-checking bench for sync_fifo_ext in STD and FWFT modes
module tb_sync_fifo_ext;
    import fifo_pkg::*;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] s_dout, f_dout;
    logic       s_valid, f_valid, s_full, f_full, s_empty, f_empty;
    logic       s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
    logic [5:0] s_count, f_count, s_avail, f_avail;

    sync_fifo_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .MODE(FIFO_STD),
                    .AF_THRESH(28), .AE_THRESH(4)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(s_dout), .rd_valid(s_valid), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .avail(s_avail), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .MODE(FIFO_FWFT),
                    .AF_THRESH(28), .AE_THRESH(4)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(f_dout), .rd_valid(f_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .avail(f_avail), .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 clk = ~clk;

    logic [7:0] mq[$];
    bit         m_ovf, m_unf, m_sv;
    logic [7:0] m_sd;
    bit         chk_en = 1'b0;
    int         n_cmp = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_sv  = 1'b0;
        m_sd  = 8'h00;
    endtask

    task automatic model_update(input bit f, input bit w, input logic [7:0] d, input bit r);
        bit rd_ok, wr_ok;
        if (f) begin
            model_clear();
        end else begin
            rd_ok = r && (mq.size() > 0);
            wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
            m_sv  = rd_ok;
            if (rd_ok) m_sd = mq.pop_front();
            if (wr_ok) mq.push_back(d);
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && !rd_ok) m_unf = 1'b1;
        end
    endtask

    task automatic check_all();
        int         n;
        logic [7:0] head;
        n    = mq.size();
        head = (n > 0) ? mq[0] : 8'h00;
        chk("std.count", 32'(s_count), n);
        chk("std.avail", 32'(s_avail), DEPTH - n);
        chk("std.full", 32'(s_full), 32'(n == DEPTH));
        chk("std.empty", 32'(s_empty), 32'(n == 0));
        chk("std.almost_full", 32'(s_af), 32'(n >= 28));
        chk("std.almost_empty", 32'(s_ae), 32'(n <= 4));
        chk("std.overflow", 32'(s_ovf), 32'(m_ovf));
        chk("std.underflow", 32'(s_unf), 32'(m_unf));
        chk("std.data_out", 32'(s_dout), 32'(m_sd));
        chk("std.rd_valid", 32'(s_valid), 32'(m_sv));
        chk("fwft.count", 32'(f_count), n);
        chk("fwft.avail", 32'(f_avail), DEPTH - n);
        chk("fwft.full", 32'(f_full), 32'(n == DEPTH));
        chk("fwft.empty", 32'(f_empty), 32'(n == 0));
        chk("fwft.almost_full", 32'(f_af), 32'(n >= 28));
        chk("fwft.almost_empty", 32'(f_ae), 32'(n <= 4));
        chk("fwft.overflow", 32'(f_ovf), 32'(m_ovf));
        chk("fwft.underflow", 32'(f_unf), 32'(m_unf));
        chk("fwft.data_out", 32'(f_dout), 32'(head));
        chk("fwft.rd_valid", 32'(f_valid), 32'(n > 0));
    endtask

    always @(negedge clk) begin
        if (chk_en && rst) check_all();
    end

    task automatic step(input bit f, input bit w, input logic [7:0] d, input bit r);
        flush   = f;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        @(posedge clk);
        model_update(f, w, d, r);
        #1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int         wp, rp;

        model_clear();
        #12;
        check_all();
        chk("reset.avail", 32'(s_avail), 32);
        chk("reset.almost_empty", 32'(s_ae), 1);
        rst = 1'b1;
        #2;
        chk_en = 1'b1;

        for (int i = 1; i <= 32; i++) begin
            step(0, 1, 8'(i), 0);
            if (i == 27) chk("af.before28", 32'(s_af), 0);
            if (i == 28) chk("af.at28", 32'(s_af), 1);
        end
        chk("fill.full", 32'(s_full), 1);
        chk("fill.count", 32'(s_count), 32);
        chk("fill.avail", 32'(s_avail), 0);

        step(0, 1, 8'h77, 1);
        chk("fullrw.count", 32'(s_count), 32);
        chk("fullrw.overflow", 32'(s_ovf), 0);
        chk("fullrw.dout", 32'(s_dout), 8'h01);

        step(0, 1, 8'h99, 0);
        chk("ovf.flag", 32'(s_ovf), 1);
        chk("ovf.count", 32'(s_count), 32);

        for (int k = 0; k < 32; k++) begin
            step(0, 0, 8'h00, 1);
            chk("drain.dout", 32'(s_dout), (k < 31) ? k + 2 : 32'h77);
            chk("drain.valid", 32'(s_valid), 1);
        end
        chk("drain.empty", 32'(s_empty), 1);
        step(0, 0, 8'h00, 1);
        chk("unf.flag", 32'(s_unf), 1);
        chk("unf.valid", 32'(s_valid), 0);

        step(1, 0, 8'h00, 0);
        step(0, 1, 8'hA5, 0);
        chk("fwft.a5.dout", 32'(f_dout), 8'hA5);
        chk("fwft.a5.valid", 32'(f_valid), 1);
        step(0, 0, 8'h00, 1);
        chk("fwft.pop.empty", 32'(f_empty), 1);

        for (int i = 0; i < 20; i++) step(0, 1, 8'($urandom), 0);
        for (int i = 0; i < 100; i++) begin
            step(0, 1, 8'($urandom), 0);
            chk("wrap.count21", 32'(s_count), 21);
            step(0, 0, 8'h00, 1);
            chk("wrap.count20", 32'(s_count), 20);
        end

        for (int i = 0; i < 600; i++) begin
            wp = (i < 300) ? 70 : 30;
            rp = (i < 300) ? 40 : 70;
            d  = 8'($urandom);
            step($urandom_range(0, 59) == 0, $urandom_range(0, 99) < wp, d,
                 $urandom_range(0, 99) < rp);
        end

        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 33; i++) step(0, 1, 8'($urandom), 0);
        for (int i = 0; i < 17; i++) step(0, 0, 8'h00, 1);
        chk("preflush.count", 32'(s_count), 15);
        chk("preflush.overflow", 32'(s_ovf), 1);
        step(1, 1, 8'h55, 0);
        chk("flush.count", 32'(s_count), 0);
        chk("flush.empty", 32'(s_empty), 1);
        chk("flush.overflow", 32'(s_ovf), 0);
        chk("flush.fwft_valid", 32'(f_valid), 0);

        for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0);
        step(0, 1, 8'h3C, 1);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        check_all();
        chk("arst.count", 32'(s_count), 0);
        chk("arst.std_valid", 32'(s_valid), 0);
        chk("arst.std_dout", 32'(s_dout), 0);
        #10;
        rst = 1'b1;
        step(0, 1, 8'h3C, 0);
        step(0, 0, 8'h00, 1);
        chk("post.dout", 32'(s_dout), 8'h3C);
        step(0, 0, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
- Next-generation single-clock FIFO.
- Adds a selectable read mode: standard registered read or first-word-fall-through (FWFT).
- Adds programmable almost-full/almost-empty flags, occupancy count, synchronous flush and sticky overflow/underflow error flags.
- Sits between streaming producers and consumers in the datapath, replacing the basic synchronous FIFO where flow control needs early warning or zero-latency head access.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH (32).
- MODE, FIFO_STD, read mode from fifo_pkg::fifo_mode_t: FIFO_STD or FIFO_FWFT.
- AF_THRESH, 28, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents and error flags.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (in FWFT mode, pop of the head word).
- data_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  data_out holds valid read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_WIDTH+1  words stored.
- avail  out  ADDR_WIDTH+1  free slots, DEPTH - count.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address memory.
  - count = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
  - Pointers wrap naturally.
  - full/empty/almost flags, count and avail are combinational from the registered pointers.
- Reset (rst=0, async):
  - wptr = rptr = 0; data_out = 0; rd_valid = 0; overflow = underflow = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0, count = 0, avail = DEPTH.
  - Memory contents are not cleared.
- Write accept: wr_en & (~full | rd_accept). When full, a simultaneous accepted read frees the slot in the same cycle. The write stores data_in at wptr and increments wptr.
- Read accept: rd_en & ~empty. A write in the same cycle as a read on an empty FIFO does not make the read legal.
- Rejected write sets overflow; rejected read sets underflow. Both stay set until flush or reset. Rejected operations leave pointers unchanged.
- Simultaneous accepted read and write: count unchanged.
- FIFO_STD mode:
  - data_out is registered; it updates to mem[rptr] one cycle after an accepted read.
  - rd_valid pulses high for exactly that cycle. data_out holds its value otherwise.
- FIFO_FWFT mode:
  - data_out = mem[rptr] continuously; rd_valid = ~empty.
  - A write into an empty FIFO is visible the cycle after the write edge.
  - An accepted rd_en pops the head; the next word appears after the edge.
- Flush (synchronous, highest priority):
  - wptr = rptr = 0; overflow = underflow = 0; rd_valid = 0; data_out = 0.
  - wr_en/rd_en in the same cycle are ignored and do not set error flags.
- Flags are level outputs with no hysteresis. A threshold crossing is visible the cycle after the causing edge.
- Reset asserted mid-operation aborts immediately. In-flight data is lost; there is no partial state.

Decomposition:
- fifo_pkg:
  - typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_t.
  - Parameter-legality check helper.
  - Shared DEPTH computation function.
- Sub-module fifo_mem_2p: register array with one synchronous write port and one asynchronous read port, parametrised on DATA_WIDTH and ADDR_WIDTH.
- Top level holds pointers, flags, error logic and the mode-dependent output stage.

Test Plan:
- Reset then write 0x01..0x20 (32 words), STD mode:
  - full=1 after the 32nd write; almost_full first high after the 28th; avail=0.
  - A 33rd write sets overflow=1, count stays 32.
- From full, read 32 words, STD mode:
  - data_out = 0x01..0x20, each one cycle after rd_en, with rd_valid pulses.
  - empty=1 at the end; a further rd_en sets underflow=1.
- FWFT mode, write 0xA5 to empty:
  - The next cycle shows data_out=0xA5, rd_valid=1.
  - rd_en pops it; empty=1 the following cycle.
- Full FIFO with simultaneous wr_en=1 (0x77) and rd_en=1: both accepted, count stays 32, overflow stays 0.
- Wrap: 100 interleaved write/read pairs over a 20-word backlog: output order matches input order, count oscillates 20/21, and pointers pass the wrap boundary correctly.
- Flush with count=15 and overflow=1, together with wr_en=1:
  - Next cycle count=0, empty=1, overflow=0.
  - The flush-cycle write is discarded.
- Deassert rst mid-stream: all outputs return to their reset values asynchronously.
